compare_arbiter: RTL and testbench

COMPARE_ARBITER -- requirements
Module: compare_arbiter

---
 rtl/compare_arbiter.sv | 111 +++++++++++
 tb/tb_compare_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/compare_arbiter.sv
// compare_arbiter: two-requester signed comparator with arbitration.
// One shared compare unit; grant, execute and respond take one cycle each.
module compare_arbiter #(
    parameter int WIDTH = 6,
    parameter bit RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             nA_LED,
    output logic             nB_LED,
    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [1:0] OP_GT  = 2'd0;
    localparam logic [1:0] OP_LT  = 2'd1;
    localparam logic [1:0] OP_EQ  = 2'd2;
    localparam logic [1:0] OP_MAX = 2'd3;

    logic [1:0]              state;
    logic                    win;
    logic                    last;
    logic                    pick;
    logic signed [WIDTH-1:0] cap_a;
    logic signed [WIDTH-1:0] cap_b;
    logic [1:0]              cap_op;
    logic [WIDTH-1:0]        calc;

    // Winner selection: a lone request wins; ties go round-robin or to req0.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = RR_EN ? ~last : 1'b0;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    // Signed compare of the captured operands only.
    always_comb begin
        calc = '0;
        unique case (cap_op)
            OP_GT:  calc = {{(WIDTH-1){1'b0}}, (cap_a > cap_b)};
            OP_LT:  calc = {{(WIDTH-1){1'b0}}, (cap_a < cap_b)};
            OP_EQ:  calc = {{(WIDTH-1){1'b0}}, (cap_a == cap_b)};
            OP_MAX: calc = (cap_b > cap_a) ? cap_b : cap_a;
            default: calc = '0;
        endcase
    end

    // FSM, operand capture on arbitration, result load leaving EXEC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            win    <= 1'b0;
            last   <= 1'b1;
            cap_a  <= '0;
            cap_b  <= '0;
            cap_op <= OP_GT;
            result <= '0;
            nA_LED <= 1'b0;
            nB_LED <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state  <= GRANT;
                        win    <= pick;
                        last   <= pick;
                        cap_a  <= pick ? a1 : a0;
                        cap_b  <= pick ? b1 : b0;
                        cap_op <= pick ? op1 : op0;
                        nA_LED <= pick ? a1[WIDTH-1] : a0[WIDTH-1];
                        nB_LED <= pick ? b1[WIDTH-1] : b0[WIDTH-1];
                    end
                end
                GRANT: state <= EXEC;
                EXEC: begin
                    state  <= RESP;
                    result <= calc;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign gnt0  = (state == GRANT) && !win;
    assign gnt1  = (state == GRANT) &&  win;
    assign done0 = (state == RESP)  && !win;
    assign done1 = (state == RESP)  &&  win;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_compare_arbiter.sv
// tb_compare_arbiter: directed vectors for compare_arbiter (WIDTH=6).
// Inputs change #1 after posedge; outputs are sampled there too.
module tb_compare_arbiter;

    logic       clk;
    logic       reset_n;
    logic       req0, req1;
    logic [5:0] a0, b0, a1, b1;
    logic [1:0] op0, op1;
    logic       gnt0, gnt1, done0, done1;
    logic [5:0] result;
    logic       nA_LED, nB_LED, busy;

    int n_chk  = 0;
    int n_fail = 0;

    compare_arbiter #(.WIDTH(6), .RR_EN(1'b1)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .req0   (req0),
        .req1   (req1),
        .a0     (a0),
        .b0     (b0),
        .a1     (a1),
        .b1     (b1),
        .op0    (op0),
        .op1    (op1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .done0  (done0),
        .done1  (done1),
        .result (result),
        .nA_LED (nA_LED),
        .nB_LED (nB_LED),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction; a is replaced by a_late right after gnt.
    task automatic run(input bit who, input logic [5:0] a, input logic [5:0] b,
                       input logic [5:0] a_late, input logic [1:0] op,
                       input logic [5:0] exp_res, input logic exp_na,
                       input logic exp_nb, input string tag);
        if (!who) begin
            a0 = a; b0 = b; op0 = op; req0 = 1'b1;
        end else begin
            a1 = a; b1 = b; op1 = op; req1 = 1'b1;
        end
        tick();
        check({tag, ".gnt"}, who ? gnt1 : gnt0, 1);
        check({tag, ".gnt_other"}, who ? gnt0 : gnt1, 0);
        check({tag, ".busy"}, busy, 1);
        if (!who) begin
            req0 = 1'b0; a0 = a_late;
        end else begin
            req1 = 1'b0; a1 = a_late;
        end
        tick();
        check({tag, ".exec_gnt"}, gnt0 | gnt1, 0);
        check({tag, ".exec_done"}, done0 | done1, 0);
        tick();
        check({tag, ".done"}, who ? done1 : done0, 1);
        check({tag, ".done_other"}, who ? done0 : done1, 0);
        check({tag, ".result"}, result, exp_res);
        check({tag, ".nA"}, nA_LED, exp_na);
        check({tag, ".nB"}, nB_LED, exp_nb);
        tick();
        check({tag, ".idle_done"}, done0 | done1, 0);
        check({tag, ".idle_busy"}, busy, 0);
        check({tag, ".hold"}, result, exp_res);
    endtask

    initial begin
        int ng;
        int both;
        int ndone;
        int gc [4];
        bit gw [4];

        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        op0 = 2'd0; op1 = 2'd0;
        #3;
        check("rst.busy", busy, 0);
        check("rst.gnt", {gnt0, gnt1}, 0);
        check("rst.done", {done0, done1}, 0);
        check("rst.result", result, 0);
        check("rst.leds", {nA_LED, nB_LED}, 0);
        #9 reset_n = 1'b1;
        tick();
        check("idle.busy", busy, 0);

        // 5 > -3
        run(0, 6'b000101, 6'b111101, 6'b000101, 2'd0, 6'd1, 0, 1, "gt0");
        // -32 < 31, then MAX
        run(0, 6'b100000, 6'b011111, 6'b100000, 2'd1, 6'd1, 1, 0, "lt0");
        run(0, 6'b100000, 6'b011111, 6'b100000, 2'd3, 6'b011111, 1, 0,
            "max0");
        // -8 == -8, then GT false
        run(1, 6'b111000, 6'b111000, 6'b111000, 2'd2, 6'd1, 1, 1, "eq1");
        run(1, 6'b111000, 6'b111000, 6'b111000, 2'd0, 6'd0, 1, 1, "gt1");
        // MAX(10, -5), a0 changed to -20 after gnt
        run(0, 6'b001010, 6'b111011, 6'b101100, 2'd3, 6'd10, 0, 1, "late");

        // Reset during EXEC
        a0 = 6'b111101; b0 = 6'b111100; op0 = 2'd3; req0 = 1'b1;
        tick();
        check("abort.gnt", gnt0, 1);
        check("abort.leds", {nA_LED, nB_LED}, 2'b11);
        req0 = 1'b0;
        tick();
        check("abort.exec", busy, 1);
        reset_n = 1'b0;
        #1;
        check("abort.busy", busy, 0);
        check("abort.result", result, 0);
        check("abort.leds0", {nA_LED, nB_LED}, 0);
        check("abort.gd", {gnt0, gnt1, done0, done1}, 0);
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done0 || done1) ndone++;
        end
        check("abort.no_done", ndone, 0);
        run(0, 6'd7, 6'd7, 6'd7, 2'd2, 6'd1, 0, 0, "post");

        // Fresh reset, then simultaneous held requests
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        a0 = 6'd1; b0 = 6'd2; op0 = 2'd1;
        a1 = 6'd3; b1 = 6'd3; op1 = 2'd2;
        req0 = 1'b1; req1 = 1'b1;
        ng = 0;
        both = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if ((gnt0 && gnt1) || (done0 && done1)) both++;
            if (gnt0 || gnt1) begin
                if (ng < 4) begin
                    gc[ng] = c;
                    gw[ng] = gnt1;
                end
                ng++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("rr.count", ng, 4);
        check("rr.excl", both, 0);
        for (int i = 0; i < 4; i++) begin
            if (i < ng) begin
                check($sformatf("rr.who%0d", i), gw[i], i % 2);
                check($sformatf("rr.cyc%0d", i), gc[i], 1 + 4 * i);
            end
        end
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
